// File: rtl/cpu_pkg.sv
// Shared CPU types: opcode codes and the instr[31:21] match/mask constants used by fetch decode.
package cpu_pkg;
  localparam int INSTR_W = 32;

  typedef enum logic [3:0] {
    PC_INIT = 4'd0,
    ADDI    = 4'd1,
    ADDS    = 4'd2,
    BLT     = 4'd3,
    B       = 4'd4,
    CBZ     = 4'd5,
    LDUR    = 4'd6,
    LSL     = 4'd7,
    LSR     = 4'd8,
    MUL     = 4'd9,
    STUR    = 4'd10,
    SUBS    = 4'd11,
    INV     = 4'd12
  } opcode_t;

  // Exact 11-bit opcodes
  localparam logic [10:0] M_ADDS  = 11'b10101011000;
  localparam logic [10:0] M_LDUR  = 11'b11111000010;
  localparam logic [10:0] M_LSL   = 11'b11010011011;
  localparam logic [10:0] M_LSR   = 11'b11010011010;
  localparam logic [10:0] M_MUL   = 11'b10011011000;
  localparam logic [10:0] M_STUR  = 11'b11111000000;
  localparam logic [10:0] M_SUBS  = 11'b11101011000;

  // Shorter prefixes: match value with its significant-bit mask
  localparam logic [10:0] M_ADDI  = 11'b10010001000;
  localparam logic [10:0] K_ADDI  = 11'b11111111110;
  localparam logic [10:0] M_BCOND = 11'b01010100000;
  localparam logic [10:0] K_BCOND = 11'b11111111000;
  localparam logic [10:0] M_CBZ   = 11'b10110100000;
  localparam logic [10:0] K_CBZ   = 11'b11111111000;
  localparam logic [10:0] M_B     = 11'b00010100000;
  localparam logic [10:0] K_B     = 11'b11111100000;

  localparam logic [4:0]  COND_LT = 5'b01011;
endpackage

// File: rtl/opcode_decode.sv
// Combinational classifier: 32-bit instruction word -> 4-bit opcode code, longest prefix first.
module opcode_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode
);
  logic [10:0] op;
  logic        unused_fields;

  assign op            = instr[31:21];
  assign unused_fields = ^instr[20:5];

  always_comb begin
    opcode = INV;
    if (op == M_ADDS)                      opcode = ADDS;
    else if (op == M_LDUR)                 opcode = LDUR;
    else if (op == M_LSL)                  opcode = LSL;
    else if (op == M_LSR)                  opcode = LSR;
    else if (op == M_MUL)                  opcode = MUL;
    else if (op == M_STUR)                 opcode = STUR;
    else if (op == M_SUBS)                 opcode = SUBS;
    else if ((op & K_ADDI) == M_ADDI)      opcode = ADDI;
    else if ((op & K_BCOND) == M_BCOND)    opcode = (instr[4:0] == COND_LT) ? BLT : INV;
    else if ((op & K_CBZ) == M_CBZ)        opcode = CBZ;
    else if ((op & K_B) == M_B)            opcode = B;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with PC register and IF/ID pipeline register.
// Define ILLEGAL_HALT_EN to halt fetch after delivering an illegal (INV) word.
//
// state   | meaning
// INIT    | first cycle after reset, IF/ID bubble, PC held
// RUN     | fetching: branch redirect > stall > normal capture
// HALT    | frozen on illegal word, left only by br_taken or reset
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               PC_W     = 64,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [31:0]       id_instr,
  output logic [3:0]        id_opcode,
  output logic              halted
);
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

`ifdef ILLEGAL_HALT_EN
  localparam bit HALT_ON_INV = 1'b1;
`else
  localparam bit HALT_ON_INV = 1'b0;
`endif

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [3:0]      dec_opcode;

  opcode_decode u_dec (
    .instr  (imem_rdata),
    .opcode (dec_opcode)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_instr  <= '0;
      id_opcode <= PC_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          state     <= ST_RUN;
          id_valid  <= 1'b0;
          id_instr  <= '0;
          id_opcode <= PC_INIT;
        end
        ST_RUN: begin
          if (br_taken) begin
            pc        <= br_target;
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_opcode <= PC_INIT;
          end else if (!stall) begin
            pc        <= pc + PC_W'(4);
            id_valid  <= 1'b1;
            id_pc     <= pc;
            id_instr  <= imem_rdata;
            id_opcode <= dec_opcode;
            if (HALT_ON_INV && dec_opcode == INV) state <= ST_HALT;
          end
        end
        ST_HALT: begin
          // An older branch may squash the illegal word, so br_taken reopens fetch.
          id_valid  <= 1'b0;
          id_instr  <= '0;
          id_opcode <= PC_INIT;
          if (br_taken) begin
            pc    <= br_target;
            state <= ST_RUN;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef ILLEGAL_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed sequences plus randomized stall/branch traffic vs a reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [3:0]  id_opcode;
  logic        halted;

  logic [31:0] mem [0:63];

`ifdef ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [31:0] W_ADDI = 32'h91000421;
  localparam logic [31:0] W_ADDS = 32'hAB020020;
  localparam logic [31:0] W_LDUR = 32'hF8400020;
  localparam logic [31:0] W_STUR = 32'hF8000020;
  localparam logic [31:0] W_LSL  = 32'hD3600000;
  localparam logic [31:0] W_LSR  = 32'hD3400000;
  localparam logic [31:0] W_MUL  = 32'h9B000000;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_opcode  (id_opcode),
    .halted     (halted)
  );

  assign imem_rdata = mem[imem_addr[7:2]];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first table entry whose masked bits match wins; no hit means INV.
  logic [31:0] d_mask  [11] = '{32'hFFC00000, 32'hFFE00000, 32'hFF00001F, 32'hFC000000,
                                32'hFF000000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
                                32'hFFE00000, 32'hFFE00000, 32'hFFE00000};
  logic [31:0] d_match [11] = '{32'h91000000, 32'hAB000000, 32'h5400000B, 32'h14000000,
                                32'hB4000000, 32'hF8400000, 32'hD3600000, 32'hD3400000,
                                32'h9B000000, 32'hF8000000, 32'hEB000000};

  function automatic logic [3:0] ref_dec(input logic [31:0] w);
    for (int i = 0; i < 11; i++)
      if ((w & d_mask[i]) == d_match[i]) return 4'(i + 1);
    return 4'd12;
  endfunction

  logic [63:0] m_pc, m_id_pc;
  logic [31:0] m_instr;
  logic [3:0]  m_op;
  bit          m_valid;
  int          m_mode;   // 0 = first cycle after reset, 1 = fetching, 2 = halted

  task automatic model_reset();
    m_pc = 64'h0; m_id_pc = 64'h0; m_instr = 32'h0; m_op = 4'd0; m_valid = 0; m_mode = 0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    w = mem[m_pc[7:2]];
    if (m_mode == 0) begin
      m_valid = 0; m_op = 4'd0; m_mode = 1;
    end else if (m_mode == 1) begin
      if (br_taken) begin
        m_pc = br_target; m_valid = 0; m_op = 4'd0;
      end else if (!stall) begin
        m_valid = 1; m_id_pc = m_pc; m_instr = w; m_op = ref_dec(w);
        m_pc = m_pc + 64'd4;
        if (HALT_EN && m_op == 4'd12) m_mode = 2;
      end
    end else begin
      m_valid = 0; m_op = 4'd0;
      if (br_taken) begin
        m_pc = br_target; m_mode = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_addr"},   imem_addr, m_pc);
    chk({tag, "_valid"},  64'(id_valid), 64'(m_valid));
    chk({tag, "_op"},     64'(id_opcode), 64'(m_op));
    chk({tag, "_halted"}, 64'(halted), 64'(m_mode == 2));
    if (m_valid) begin
      chk({tag, "_pc"},    id_pc, m_id_pc);
      chk({tag, "_instr"}, 64'(id_instr), 64'(m_instr));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"},  64'(id_valid), 64'd0);
    chk({tag, "_pc"},     id_pc, 64'd0);
    chk({tag, "_instr"},  64'(id_instr), 64'd0);
    chk({tag, "_op"},     64'(id_opcode), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_addr"},   imem_addr, 64'd0);
  endtask

  // Reset asserted between edges; outputs must clear before the next rising edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_seq1(input string tag);
    logic [3:0]  ops [4] = '{4'd1, 4'd2, 4'd6, 4'd10};
    logic [63:0] pcs [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
    cycle({tag, "_init"});
    chk({tag, "_init_bubble"}, 64'(id_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(tag);
      chk({tag, "_seq_op"}, 64'(id_opcode), 64'(ops[i]));
      chk({tag, "_seq_pc"}, id_pc, pcs[i]);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0;
    for (int i = 0; i < 64; i++) mem[i] = W_ADDI;
    mem[0] = W_ADDI; mem[1] = W_ADDS; mem[2] = W_LDUR; mem[3] = W_STUR;
    mem[16] = 32'h5400000B; mem[17] = W_LSL; mem[18] = W_LSR;
    mem[19] = 32'h54000000; mem[20] = 32'hFFFFFFFF;
    model_reset();
    #12 check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;

    // Basic stream
    run_seq1("t1");

    // Stall held three cycles at pc=8
    async_reset("t2rst");
    cycle("t2_init");
    cycle("t2"); cycle("t2");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("t2_stall");
      chk("t2_stall_addr", imem_addr, 64'h8);
      chk("t2_stall_idpc", id_pc, 64'h4);
      chk("t2_stall_op", 64'(id_opcode), 64'd2);
    end
    stall = 1'b0;
    cycle("t2_resume");
    chk("t2_resume_op", 64'(id_opcode), 64'd6);

    // Branch overrides stall, then encoding corners at the target
    stall = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    cycle("t3_br");
    chk("t3_flush_valid", 64'(id_valid), 64'd0);
    stall = 1'b0; br_taken = 1'b0;
    cycle("t3");
    chk("t3_target_pc", id_pc, 64'h40);
    chk("t4_blt", 64'(id_opcode), 64'd3);
    cycle("t4"); chk("t4_lsl", 64'(id_opcode), 64'd7);
    cycle("t4"); chk("t4_lsr", 64'(id_opcode), 64'd8);
    cycle("t4"); chk("t4_bcond_eq", 64'(id_opcode), 64'd12);
    if (!HALT_EN) begin
      cycle("t4"); chk("t4_all_ones", 64'(id_opcode), 64'd12);
    end
    chk("t4_ref_ones", 64'(ref_dec(32'hFFFFFFFF)), 64'd12);

`ifdef ILLEGAL_HALT_EN
    // Illegal word at 0x10 halts fetch, branch resumes
    mem[4] = 32'hFFFFFFFF;
    async_reset("t5rst");
    run_seq1("t5");
    cycle("t5_inv");
    chk("t5_inv_valid", 64'(id_valid), 64'd1);
    chk("t5_inv_op", 64'(id_opcode), 64'd12);
    chk("t5_inv_pc", id_pc, 64'h10);
    cycle("t5_halt");
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_frozen", imem_addr, 64'h14);
    chk("t5_bubble", 64'(id_valid), 64'd0);
    cycle("t5_halt2");
    chk("t5_frozen2", imem_addr, 64'h14);
    br_taken = 1'b1; br_target = 64'h0;
    cycle("t5_br");
    br_taken = 1'b0;
    chk("t5_unhalt", 64'(halted), 64'd0);
    cycle("t5_resume");
    chk("t5_resume_op", 64'(id_opcode), 64'd1);
    mem[4] = W_ADDI;
`endif

    // Mid-run async reset, sequence repeats
    cycle("t6_run"); cycle("t6_run");
    async_reset("t6rst");
    run_seq1("t6");

    // Randomized traffic
    for (int i = 0; i < 64; i++) begin
      int sel;
      sel = int'($urandom_range(0, 13));
      if (sel < 11) mem[i] = d_match[sel] | ($urandom & ~d_mask[sel]);
      else if (sel == 11) mem[i] = 32'h54000000 | 32'($urandom_range(0, 31));
      else mem[i] = $urandom;
    end
    for (int n = 0; n < 1500; n++) begin
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = {56'h0, 6'($urandom_range(0, 63)), 2'b00};
      cycle("rnd");
    end
    stall = 1'b0; br_taken = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
